// File: rtl/first_nios2_sysid_pkg.sv
// Shared types and constants for the first_nios2 system-ID boot checker.
package first_nios2_sysid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic id_match;
    logic ts_match;
    logic timeout_err;
    logic pass;
  } result_t;

endpackage

// File: rtl/first_nios2_sysid_rd_timer.sv
// Per-transaction watchdog: counts cycles spent in a request/wait phase and
// flags expiry one cycle ahead so the FSM leaves on the expiring edge.
module first_nios2_sysid_rd_timer
  import first_nios2_sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CMP_W = CNT_W + 1;

  logic [CNT_W-1:0] count_q;

  // Expires when this cycle is the TIMEOUT_CYCLES-th one since clear.
  assign expired_c = enable &&
                     ((CMP_W'(count_q) + CMP_W'(1)) >= CMP_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/first_nios2_sysid_checker.sv
// Avalon-MM read master that fetches sysid word 0 (ID) and word 1 (timestamp)
// and checks them against build-time values. SYSID_CHECK_TIMEOUT_EN adds a
// per-read watchdog; without it the FSM waits indefinitely.
module first_nios2_sysid_checker
  import first_nios2_sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1521070873
`ifdef SYSID_CHECK_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT_CYCLES     = 255
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_match,
  output logic              ts_match,
  output logic              timeout_err,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  state_e            state_q, state_d;
  result_t           res_q, res_d;
  logic              read_d, address_d, done_d, busy_d;
  logic [DATA_W-1:0] id_d, ts_d;
  logic              expired_c;

  assign id_match    = res_q.id_match;
  assign ts_match    = res_q.ts_match;
  assign timeout_err = res_q.timeout_err;
  assign pass        = res_q.pass;

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    read_d    = 1'b0;
    address_d = address;
    done_d    = 1'b0;
    res_d     = res_q;
    id_d      = id_value;
    ts_d      = ts_value;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_REQ_ID;
          read_d    = 1'b1;
          address_d = SYSID_ADDR_ID;
          res_d     = '0;
        end
      end
      ST_REQ_ID: begin
        if (expired_c) begin
          state_d           = ST_DONE;
          done_d            = 1'b1;
          res_d.timeout_err = 1'b1;
        end else if (waitrequest) begin
          read_d = 1'b1;
        end else begin
          state_d = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: begin
        if (readdatavalid) begin
          id_d      = readdata;
          state_d   = ST_REQ_TS;
          read_d    = 1'b1;
          address_d = SYSID_ADDR_TS;
        end else if (expired_c) begin
          state_d           = ST_DONE;
          done_d            = 1'b1;
          res_d.timeout_err = 1'b1;
        end
      end
      ST_REQ_TS: begin
        if (expired_c) begin
          state_d           = ST_DONE;
          done_d            = 1'b1;
          res_d.timeout_err = 1'b1;
          res_d.id_match    = (id_value == EXPECTED_ID);
        end else if (waitrequest) begin
          read_d = 1'b1;
        end else begin
          state_d = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (readdatavalid) begin
          ts_d           = readdata;
          state_d        = ST_DONE;
          done_d         = 1'b1;
          res_d.id_match = (id_value == EXPECTED_ID);
          res_d.ts_match = (readdata == EXPECTED_TIMESTAMP);
          res_d.pass     = (id_value == EXPECTED_ID) &&
                           (readdata == EXPECTED_TIMESTAMP);
        end else if (expired_c) begin
          state_d           = ST_DONE;
          done_d            = 1'b1;
          res_d.timeout_err = 1'b1;
          res_d.id_match    = (id_value == EXPECTED_ID);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      read     <= 1'b0;
      address  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_q    <= '0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state_q  <= state_d;
      read     <= read_d;
      address  <= address_d;
      busy     <= busy_d;
      done     <= done_d;
      res_q    <= res_d;
      id_value <= id_d;
      ts_value <= ts_d;
    end
  end

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic timer_clear_c, timer_en_c;

  assign timer_en_c    = (state_q == ST_REQ_ID) || (state_q == ST_WAIT_ID) ||
                         (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);
  // Restart the budget on each entry into a request phase.
  assign timer_clear_c = ((state_d == ST_REQ_ID) && (state_q != ST_REQ_ID)) ||
                         ((state_d == ST_REQ_TS) && (state_q != ST_REQ_TS));

  first_nios2_sysid_rd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (timer_clear_c),
    .enable    (timer_en_c),
    .expired_c (expired_c)
  );
`else
  assign expired_c = 1'b0;
`endif

endmodule
